// File: rtl/scic_io_pkg.sv
// Shared I/O constants for the SCIC front panel, plus the per-bit debounce
// state encoding used by switch_debouncer.
package scic_io_pkg;

  localparam int unsigned SWITCH_WIDTH          = 4;
  localparam int unsigned LED_WIDTH             = 4;
  localparam int unsigned DEFAULT_STABLE_CYCLES = 1000;

  // STABLE: synchronized input agrees with the debounced level, counter idle.
  // PENDING: input disagrees, counting toward the terminal count.
  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit switch conditioner: two-flop synchronizer, stability counter and
// one-cycle change strobe.
//
// Ports:
//   clock    - system clock, rising edge
//   reset    - synchronous, active-high
//   raw      - asynchronous switch pin
//   level    - debounced value (registered)
//   changed  - registered pulse, high in the first cycle the new level is seen
//   update_c - combinational: level will update at the coming edge
module debounce_bit
  import scic_io_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic changed,
  output logic update_c
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  db_state_e       state;
  db_state_e       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic            level_next;
  logic            mismatch;

  // Synchronizer: raw only ever reaches the rest of the logic through sync2.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // State, counter, debounced level and strobe registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= DB_STABLE;
      cnt     <= '0;
      level   <= 1'b0;
      changed <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      level   <= level_next;
      changed <= update_c;
    end
  end

  assign mismatch = (sync2 != level);

  // Next-state: a match anywhere restarts the count, so glitches shorter than
  // STABLE_CYCLES never move the level.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = level;
    update_c   = 1'b0;
    case (state)
      DB_STABLE: begin
        if (mismatch) begin
          state_next = DB_PENDING;
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next = '0;
        end
      end
      DB_PENDING: begin
        if (!mismatch) begin
          state_next = DB_STABLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          // Terminal count: adopt the synchronized value; counter never wraps.
          state_next = DB_STABLE;
          cnt_next   = '0;
          level_next = sync2;
          update_c   = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the raw front-panel switches feeding the SCIC switches port.
// Each bit is conditioned independently by a debounce_bit instance.
//
// Ports:
//   clock        - system clock, rising edge
//   reset        - synchronous, active-high
//   switches_raw - asynchronous switch pins
//   switches     - debounced switch value
//   changed      - per-bit one-cycle pulse when that bit of switches updates
//   any_changed  - OR of changed (registered alongside it)
module switch_debouncer
  import scic_io_pkg::*;
#(
  parameter int unsigned WIDTH         = SWITCH_WIDTH,
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches_raw,
  output logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] changed,
  output logic             any_changed
);

  logic [WIDTH-1:0] update_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clock    (clock),
      .reset    (reset),
      .raw      (switches_raw[i]),
      .level    (switches[i]),
      .changed  (changed[i]),
      .update_c (update_c[i])
    );
  end

  // Registered from the same update terms as changed, so it equals |changed.
  always_ff @(posedge clock) begin
    if (reset) begin
      any_changed <= 1'b0;
    end else begin
      any_changed <= |update_c;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
module tb_switch_debouncer;

  localparam int unsigned W  = 4;
  localparam int unsigned SC = 4;

  logic         clock;
  logic         reset;
  logic [W-1:0] switches_raw;
  logic [W-1:0] switches;
  logic [W-1:0] changed;
  logic         any_changed;

  int total = 0;
  int bad   = 0;

  switch_debouncer #(
    .WIDTH(W),
    .STABLE_CYCLES(SC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .switches_raw (switches_raw),
    .switches     (switches),
    .changed      (changed),
    .any_changed  (any_changed)
  );

  initial clock = 1'b0;
  always #50 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    switches_raw = 4'b1111;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (switches !== 4'b0000) begin
        bad++; $display("FAIL reset_switches edge=%0d got=%b exp=%b", i, switches, 4'b0000);
      end
      total++;
      if (changed !== 4'b0000) begin
        bad++; $display("FAIL reset_changed edge=%0d got=%b exp=%b", i, changed, 4'b0000);
      end
      total++;
      if (any_changed !== 1'b0) begin
        bad++; $display("FAIL reset_any edge=%0d got=%b exp=%b", i, any_changed, 1'b0);
      end
    end
    reset = 1'b0;
    switches_raw = 4'b0000;
    for (int i = 0; i < 8; i++) step();
    total++;
    if (switches !== 4'b0000) begin
      bad++; $display("FAIL reset_idle got=%b exp=%b", switches, 4'b0000);
    end
  endtask

  task automatic test_clean_step();
    logic [W-1:0] exp_sw;
    logic [W-1:0] exp_ch;
    switches_raw = 4'b0001;
    for (int n = 1; n <= 9; n++) begin
      step();
      exp_sw = (n >= 6) ? 4'b0001 : 4'b0000;
      exp_ch = (n == 6) ? 4'b0001 : 4'b0000;
      total++;
      if (switches !== exp_sw) begin
        bad++; $display("FAIL step_up_switches edge=%0d got=%b exp=%b", n, switches, exp_sw);
      end
      total++;
      if (changed !== exp_ch) begin
        bad++; $display("FAIL step_up_changed edge=%0d got=%b exp=%b", n, changed, exp_ch);
      end
      total++;
      if (any_changed !== (n == 6)) begin
        bad++; $display("FAIL step_up_any edge=%0d got=%b exp=%b", n, any_changed, (n == 6));
      end
    end
    // Release back to idle with the same latency.
    switches_raw = 4'b0000;
    for (int n = 1; n <= 8; n++) begin
      step();
      exp_sw = (n >= 6) ? 4'b0000 : 4'b0001;
      exp_ch = (n == 6) ? 4'b0001 : 4'b0000;
      total++;
      if (switches !== exp_sw) begin
        bad++; $display("FAIL step_down_switches edge=%0d got=%b exp=%b", n, switches, exp_sw);
      end
      total++;
      if (changed !== exp_ch) begin
        bad++; $display("FAIL step_down_changed edge=%0d got=%b exp=%b", n, changed, exp_ch);
      end
    end
  endtask

  // A 3-clock pulse (STABLE_CYCLES-1) must never reach switches.
  task automatic test_glitch();
    switches_raw = 4'b0100;
    for (int n = 1; n <= 14; n++) begin
      step();
      if (n == 3) switches_raw = 4'b0000;
      total++;
      if (switches !== 4'b0000) begin
        bad++; $display("FAIL glitch_switches edge=%0d got=%b exp=%b", n, switches, 4'b0000);
      end
      total++;
      if (changed !== 4'b0000 || any_changed !== 1'b0) begin
        bad++; $display("FAIL glitch_changed edge=%0d got=%b/%b exp=%b/%b",
                        n, changed, any_changed, 4'b0000, 1'b0);
      end
    end
  endtask

  // A 4-clock pulse is the shortest accepted; raw has already returned low on
  // the terminal-count cycle, yet sync2 still mismatches so the update lands.
  task automatic test_min_pulse();
    logic [W-1:0] exp_sw;
    logic [W-1:0] exp_ch;
    switches_raw = 4'b0100;
    for (int n = 1; n <= 14; n++) begin
      step();
      if (n == 4) switches_raw = 4'b0000;
      exp_sw = (n >= 6 && n <= 9) ? 4'b0100 : 4'b0000;
      exp_ch = (n == 6 || n == 10) ? 4'b0100 : 4'b0000;
      total++;
      if (switches !== exp_sw) begin
        bad++; $display("FAIL min_pulse_switches edge=%0d got=%b exp=%b", n, switches, exp_sw);
      end
      total++;
      if (changed !== exp_ch) begin
        bad++; $display("FAIL min_pulse_changed edge=%0d got=%b exp=%b", n, changed, exp_ch);
      end
    end
  endtask

  task automatic test_independent();
    logic [W-1:0] exp_sw;
    logic [W-1:0] exp_ch;
    switches_raw = 4'b0001;
    for (int n = 1; n <= 11; n++) begin
      step();
      if (n == 2) switches_raw = 4'b1001;
      exp_sw = ((n >= 6) ? 4'b0001 : 4'b0000) | ((n >= 8) ? 4'b1000 : 4'b0000);
      exp_ch = ((n == 6) ? 4'b0001 : 4'b0000) | ((n == 8) ? 4'b1000 : 4'b0000);
      total++;
      if (switches !== exp_sw) begin
        bad++; $display("FAIL indep_switches edge=%0d got=%b exp=%b", n, switches, exp_sw);
      end
      total++;
      if (changed !== exp_ch) begin
        bad++; $display("FAIL indep_changed edge=%0d got=%b exp=%b", n, changed, exp_ch);
      end
      total++;
      if (any_changed !== (exp_ch != 4'b0000)) begin
        bad++; $display("FAIL indep_any edge=%0d got=%b exp=%b", n, any_changed, (exp_ch != 4'b0000));
      end
    end
    switches_raw = 4'b0000;
    for (int n = 0; n < 10; n++) step();
    total++;
    if (switches !== 4'b0000) begin
      bad++; $display("FAIL indep_release got=%b exp=%b", switches, 4'b0000);
    end
  endtask

  task automatic test_reset_mid_count();
    logic [W-1:0] exp_sw;
    logic [W-1:0] exp_ch;
    switches_raw = 4'b1010;
    for (int n = 1; n <= 13; n++) begin
      if (n == 5) reset = 1'b1;
      step();
      if (n == 5) reset = 1'b0;
      exp_sw = (n >= 11) ? 4'b1010 : 4'b0000;
      exp_ch = (n == 11) ? 4'b1010 : 4'b0000;
      total++;
      if (switches !== exp_sw) begin
        bad++; $display("FAIL rst_mid_switches edge=%0d got=%b exp=%b", n, switches, exp_sw);
      end
      total++;
      if (changed !== exp_ch) begin
        bad++; $display("FAIL rst_mid_changed edge=%0d got=%b exp=%b", n, changed, exp_ch);
      end
    end
    switches_raw = 4'b0000;
    for (int n = 0; n < 10; n++) step();
    total++;
    if (switches !== 4'b0000) begin
      bad++; $display("FAIL rst_mid_release got=%b exp=%b", switches, 4'b0000);
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] prev;
    logic [W-1:0] v;
    logic [W-1:0] exp_sw;
    logic [W-1:0] exp_ch;
    prev = 4'b0000;
    for (int k = 0; k < 16; k++) begin
      v = W'(k);
      switches_raw = v;
      for (int n = 1; n <= 10; n++) begin
        step();
        exp_sw = (n >= 6) ? v : prev;
        exp_ch = (n == 6) ? (v ^ prev) : 4'b0000;
        total++;
        if (switches !== exp_sw) begin
          bad++; $display("FAIL sweep_switches val=%0d edge=%0d got=%b exp=%b", k, n, switches, exp_sw);
        end
        total++;
        if (changed !== exp_ch) begin
          bad++; $display("FAIL sweep_changed val=%0d edge=%0d got=%b exp=%b", k, n, changed, exp_ch);
        end
        total++;
        if (any_changed !== (exp_ch != 4'b0000)) begin
          bad++; $display("FAIL sweep_any val=%0d edge=%0d got=%b exp=%b",
                          k, n, any_changed, (exp_ch != 4'b0000));
        end
      end
      prev = v;
    end
  endtask

  initial begin
    reset = 1'b1;
    switches_raw = 4'b0000;
    test_reset();
    test_clean_step();
    test_glitch();
    test_min_pulse();
    test_independent();
    test_reset_mid_count();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
